// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM.
// Owns the binary read/write pointers and publishes registered Gray-coded
// copies for a later dual-clock variant. Status flags, occupancy and the
// error pulses are all registered on the same edge as the pointers.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next, count_next;
    logic          push, pop;
    logic          full_next, empty_next;

    // Acceptance looks only at the registered flags, so a pop never frees
    // room for a same-cycle push (and vice versa).
    assign push      = wr_en & ~full;
    assign pop       = rd_en & ~empty;
    assign mem_we    = push;
    assign mem_re    = pop;
    assign mem_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_raddr = rd_ptr[ADDR_WIDTH-1:0];

    // Next-state pointers, occupancy and the flags derived from them.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (push) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
        full_next  = (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]);
        empty_next = (wr_ptr_next == rd_ptr_next);
    end

    // Register pointers, Gray copies, flags and error pulses together so
    // status has zero lag relative to the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_ptr_gray  <= '0;
            rd_ptr_gray  <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            wr_ptr_gray  <= wr_ptr_next ^ (wr_ptr_next >> 1);
            rd_ptr_gray  <= rd_ptr_next ^ (rd_ptr_next >> 1);
            count        <= count_next;
            full         <= full_next;
            empty        <= empty_next;
            almost_full  <= (count_next >= AF_TH);
            almost_empty <= (count_next <= AE_TH);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed fill/overflow/drain/wrap/reset steps
// followed by random traffic, checked against an occupancy-based model.
module tb_sync_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b1;
    logic          rd_en = 1'b1;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [AW:0]   wr_ptr_gray, rd_ptr_gray, count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: total items written/read (mod PMOD) and the occupancy.
    int m_wr = 0, m_rd = 0, m_cnt = 0;
    bit m_ovf = 0, m_unf = 0, m_valid = 0;
    logic [AW:0] prev_wg = '0, prev_rg = '0;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_raddr(mem_raddr),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int p);
        int g;
        g = p ^ (p >> 1);
        return AW'(0) | g[AW:0];
    endfunction

    // One clock cycle: drive inputs, check strobes, clock, update model, check state.
    task automatic step(input logic w, input logic r, input logic rs);
        bit m_full, m_empty, push, pop;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        rst   = rs;
        m_full  = (m_cnt == DEPTH);
        m_empty = (m_cnt == 0);
        push = w && !m_full;
        pop  = r && !m_empty;
        #1;
        if (m_valid) begin
            chk("mem_we", 32'(mem_we), 32'(push));
            chk("mem_re", 32'(mem_re), 32'(pop));
            chk("mem_waddr", 32'(mem_waddr), 32'(m_wr % DEPTH));
            chk("mem_raddr", 32'(mem_raddr), 32'(m_rd % DEPTH));
        end
        @(posedge clk);
        if (rs) begin
            m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf = w && m_full;
            m_unf = r && m_empty;
            if (push) begin m_wr = (m_wr + 1) % PMOD; m_cnt++; end
            if (pop)  begin m_rd = (m_rd + 1) % PMOD; m_cnt--; end
        end
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= AF_TH));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE_TH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray(m_wr)));
        chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray(m_rd)));
        chk("not_full_and_empty", 32'(full & empty), 32'(0));
        if (m_valid && !rs) begin
            chk("wr_gray_onebit", 32'($countones(wr_ptr_gray ^ prev_wg)), 32'(push ? 1 : 0));
            chk("rd_gray_onebit", 32'($countones(rd_ptr_gray ^ prev_rg)), 32'(pop ? 1 : 0));
        end
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
        m_valid = 1;
    endtask

    initial begin
        // Reset held two cycles with both requests asserted
        step(1, 1, 1);
        step(1, 1, 1);
        chk("reset_wr_gray", 32'(wr_ptr_gray), 32'h00);
        chk("reset_rd_gray", 32'(rd_ptr_gray), 32'h00);

        // Fill
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_wr_gray", 32'(wr_ptr_gray), 32'b11000);

        // Overflow, then push+pop while full
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 1, 0);
        chk("pushpop_full_count", 32'(count), 32'd15);

        // Top up then drain, then underflow
        step(1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
        chk("drain_empty", 32'(empty), 32'h1);
        step(0, 1, 0);
        step(0, 0, 0);

        // Wrap from half-full
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0);
        chk("wrap_count", 32'(count), 32'd8);

        // Mid-operation reset at count 9
        step(1, 0, 0);
        step(0, 0, 1);
        chk("midrst_count", 32'(count), 32'd0);
        step(1, 0, 0);
        chk("midrst_push_count", 32'(count), 32'd1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
